// File: rtl/sregister_uni.sv
// Parametrised universal shift register: parallel load, left/right shift with
// enable, shift counter with frame-done pulse. Optional rotate via SREG_ROTATE_EN.
module sregister_uni #(
  parameter int           N         = 8,
  parameter logic [N-1:0] RESET_VAL = '0,
  parameter int           CW        = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [N-1:0]  d,
  input  logic          en,
  input  logic          dir,
  input  logic          sin,
  input  logic          rot,
  output logic [N-1:0]  q,
  output logic          sout,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic in_bit;

  // sout is always the bit the next shift will push out.
  assign sout = dir ? q[0] : q[N-1];

`ifdef SREG_ROTATE_EN
  assign in_bit = rot ? sout : sin;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign in_bit     = sin;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= RESET_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      q    <= d;
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      q <= dir ? {in_bit, q[N-1:1]} : {q[N-2:0], in_bit};
      // Frame ends on the Nth shift; counter restarts with no idle cycle.
      if (cnt == LAST) begin
        cnt  <= '0;
        done <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: doc/sregister_uni.md
# sregister_uni

Parametrised universal shift register, successor to the 8-bit serial/parallel shift register. Adds selectable shift direction, per-cycle shift enable, a shift counter with a one-cycle frame-done pulse, and an optional rotate mode. It is used as a serializer/deserializer stage between parallel datapath logic and single-bit links.

## Interface

Parameters:
- N, 8, register width in bits; legal range 2..64.
- RESET_VAL, {N{1'b0}}, value loaded into q on reset.
- CW, $clog2(N), width of the shift counter. Derived; do not override.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  parallel load strobe.
- d  input  N  parallel load data.
- en  input  1  shift enable.
- dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
- sin  input  1  serial input bit.
- rot  input  1  rotate select; used only with SREG_ROTATE_EN.
- q  output  N  register contents.
- sout  output  1  serial output bit; combinational from q and dir.
- cnt  output  CW  shifts completed since the last load, reset, or frame end.
- done  output  1  one-cycle pulse marking the end of an N-shift frame.

## Operation

- Reset (async, asserted): q = RESET_VAL, cnt = 0, done = 0, immediately without waiting for a clock edge. Reset held high overrides every other input.
- Priority at each rising edge: reset > load > en > hold.
- Load (load=1): q <= d; cnt <= 0; done <= 0. en, dir, sin and rot are ignored in that cycle.
- Shift left (load=0, en=1, dir=0): q <= {q[N-2:0], in_bit}.
- Shift right (load=0, en=1, dir=1): q <= {in_bit, q[N-1:1]}.
- in_bit = sin, except in rotate mode (see Configuration).
- sout = q[N-1] when dir=0, q[0] when dir=1. It always shows the bit that the next shift will move out. It changes combinationally with dir.
- Counter: each shift sets cnt <= cnt+1. When a shift occurs with cnt == N-1, cnt wraps to 0 and done <= 1 for the following cycle.
- done is registered. It is high for exactly one cycle after the edge carrying the Nth shift, then clears unless another frame ends on the next edge. That is impossible for N ≥ 2.
- Hold (load=0, en=0): q, cnt and done <= 0 hold their state. done deasserts on the next edge.
- Changing dir mid-frame is legal. cnt keeps counting shifts regardless of direction.
- Reset asserted mid-frame aborts the frame: cnt = 0, and no done pulse is produced for that frame.

## Timing

- Load-to-q latency: 1 cycle.
- Shift latency: 1 cycle per bit.
- done is asserted in the cycle after the edge that performs shift N. In the same cycle q holds the fully shifted value and cnt = 0.
- Frame period with en held high: N cycles. Back-to-back frames need no idle cycle.
- Load on the same edge as the Nth shift: the load wins, there is no done pulse, and cnt = 0.
- Reset release is asynchronous to clk. The first functional edge is the first rising edge after deassertion.

## Configuration

- SREG_ROTATE_EN defined:
  - When rot=1 during a shift, in_bit = the bit being shifted out: q[N-1] for a left shift, q[0] for a right shift.
  - sin is ignored.
  - N rotates restore the original q and pulse done.
- SREG_ROTATE_EN undefined:
  - The rot port is present but ignored; in_bit = sin always.
  - No rotate logic is synthesised.

## Test plan

- Reset: assert reset between edges with q = 8'hFF. Required: q = 8'h00, cnt = 0 and done = 0 before the next edge; state holds while reset stays high.
- Left serialise (N=8): load d = 8'b1001_1001, then 8 cycles with en=1, dir=0, sin=0. Required: sout sequence 1,0,0,1,1,0,0,1; final q = 8'h00; done high for one cycle after the 8th edge with cnt = 0.
- Right deserialise: after reset, 8 shifts with dir=1 and sin sequence 1,0,1,1,0,0,0,1. Required: q = 8'b1000_1101 and a done pulse. Gaps with en=0 mid-frame stretch the frame without changing the result.
- Priority: hold load=1 and en=1 together with d = 8'hA5. Required: q = 8'hA5 and cnt = 0. Load on the 8th-shift edge: no done pulse.
- Reset mid-frame: assert reset after 5 shifts. Required: q = RESET_VAL, cnt = 0, no done; the next frame needs a full 8 shifts.
- Rotate (SREG_ROTATE_EN): load 8'h81, then rot=1, dir=0, sin=0 for 8 shifts. Required: q after the first shift = 8'h03; after 8 shifts q = 8'h81 with done pulsed. With the macro undefined, the same stimulus yields q = 8'h00.
